// File: rtl/bsg_mem_1rw_sync_rv_client.sv
// Ready/valid front end for a single-port synchronous RAM.
// Read data returns through an in-order, credit-guarded response FIFO.
module bsg_mem_1rw_sync_rv_client #(
   parameter int width_p       = 8,
   parameter int els_p         = 16,
   parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
   parameter int resp_els_p    = 3
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     v_i,
   input  logic                     w_i,
   input  logic [addr_width_lp-1:0] addr_i,
   input  logic [width_p-1:0]       data_i,
   output logic                     ready_o,
   output logic                     mem_v_o,
   output logic                     mem_w_o,
   output logic [addr_width_lp-1:0] mem_addr_o,
   output logic [width_p-1:0]       mem_data_o,
   input  logic [width_p-1:0]       mem_data_i,
   output logic                     v_o,
   output logic [width_p-1:0]       data_o,
   input  logic                     yumi_i
);

   localparam int cnt_w_lp = $clog2(resp_els_p + 1);
   localparam int ptr_w_lp = (resp_els_p > 1) ? $clog2(resp_els_p) : 1;
   localparam logic [ptr_w_lp-1:0] ptr_last_lp = ptr_w_lp'(resp_els_p - 1);
   localparam logic [cnt_w_lp:0] credits_lp = (cnt_w_lp + 1)'(resp_els_p);

   logic                inflight_q, inflight_d;
   logic [cnt_w_lp-1:0] count_q, count_d;
   logic [ptr_w_lp-1:0] head_q, head_d;
   logic [ptr_w_lp-1:0] tail_q, tail_d;
   logic [width_p-1:0]  fifo_q [resp_els_p];
   logic [cnt_w_lp:0]   used;
   logic                enq, deq;

   // A request may issue only if every outstanding read has a FIFO slot.
   always_comb begin
      used    = {1'b0, count_q} + {{cnt_w_lp{1'b0}}, inflight_q};
      ready_o = reset_n_i & (used < credits_lp);
   end

   assign mem_v_o    = v_i & ready_o;
   assign mem_w_o    = w_i;
   assign mem_addr_o = addr_i;
   assign mem_data_o = data_i;

   assign enq    = inflight_q;
   assign deq    = yumi_i;
   assign v_o    = (count_q != '0);
   assign data_o = fifo_q[head_q];

   // Next state: in-flight flag, occupancy and wrapping pointers.
   always_comb begin
      inflight_d = mem_v_o & ~w_i;
      count_d    = count_q;
      head_d     = head_q;
      tail_d     = tail_q;
      if (enq) begin
         tail_d = (tail_q == ptr_last_lp) ? '0 : tail_q + 1'b1;
      end
      if (deq) begin
         head_d = (head_q == ptr_last_lp) ? '0 : head_q + 1'b1;
      end
      case ({enq, deq})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Control registers; reset drops any in-flight read and queued data.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         inflight_q <= 1'b0;
         count_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         inflight_q <= inflight_d;
         count_q    <= count_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

   // Response storage; slot contents only matter once counted.
   always_ff @(posedge clk_i) begin
      if (enq) begin
         fifo_q[tail_q] <= mem_data_i;
      end
   end

   // Simulation-only protocol checks.
   always_ff @(posedge clk_i) begin
      if (reset_n_i) begin
         assert (!(yumi_i && !v_o))
            else $error("yumi_i asserted while v_o is low");
         assert (!(mem_v_o && (els_p > 1) && (int'(addr_i) >= els_p)))
            else $error("accepted address out of range");
         assert (!(enq && !deq && (int'(count_q) == resp_els_p)))
            else $error("response fifo overflow");
      end
   end

endmodule

// File: tb/tb_bsg_mem_1rw_sync_rv_client.sv
// Bench for bsg_mem_1rw_sync_rv_client: RAM model plus queue-based
// reference of outstanding reads, directed cases then random traffic.
module tb_bsg_mem_1rw_sync_rv_client;

   localparam int W    = 8;
   localparam int ELS  = 16;
   localparam int AW   = 4;
   localparam int RESP = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          v_i = 1'b0;
   logic          w_i = 1'b0;
   logic [AW-1:0] addr_i = '0;
   logic [W-1:0]  data_i = '0;
   logic          ready_o;
   logic          mem_v_o;
   logic          mem_w_o;
   logic [AW-1:0] mem_addr_o;
   logic [W-1:0]  mem_data_o;
   logic [W-1:0]  mem_data_i;
   logic          v_o;
   logic [W-1:0]  data_o;
   logic          yumi_i = 1'b0;

   always #5 clk = ~clk;

   bsg_mem_1rw_sync_rv_client #(
      .width_p(W), .els_p(ELS), .resp_els_p(RESP)
   ) dut (
      .clk_i(clk), .reset_n_i(rst_n),
      .v_i(v_i), .w_i(w_i), .addr_i(addr_i), .data_i(data_i),
      .ready_o(ready_o),
      .mem_v_o(mem_v_o), .mem_w_o(mem_w_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .mem_data_i(mem_data_i),
      .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i)
   );

   // Synchronous RAM; read port shows garbage when no read was issued.
   logic [W-1:0] ram [ELS];
   always @(posedge clk) begin
      if (mem_v_o && mem_w_o) ram[mem_addr_o] <= mem_data_o;
      if (mem_v_o && !mem_w_o) mem_data_i <= ram[mem_addr_o];
      else mem_data_i <= W'($urandom);
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: list of accepted, not yet consumed reads with the cycle
   // from which each becomes visible.
   typedef struct {
      logic [W-1:0] d;
      int           vis;
   } resp_t;

   resp_t        rq[$];
   resp_t        e;
   logic [W-1:0] shadow [ELS];
   int           tick = 0;
   logic         m_v = 1'b0;
   logic         m_acc;

   always @(posedge clk) begin
      m_acc = v_i && rst_n && (rq.size() < RESP);
      tick++;
      if (!rst_n) begin
         rq.delete();
      end else begin
         if (yumi_i && rq.size() > 0) void'(rq.pop_front());
         if (m_acc && w_i) begin
            shadow[addr_i] = data_i;
         end else if (m_acc) begin
            e.d   = shadow[addr_i];
            e.vis = tick + 1;
            rq.push_back(e);
         end
      end
      m_v = (rq.size() > 0) && (rq[0].vis <= tick);
   end

   logic started = 1'b0;
   logic exp_rdy;

   always @(negedge clk) begin
      if (started) begin
         exp_rdy = rst_n && (rq.size() < RESP);
         chk("ready_o", ready_o, exp_rdy);
         chk("v_o", v_o, m_v);
         if (m_v) chk("data_o", data_o, rq[0].d);
         chk("mem_v_o", mem_v_o, v_i && exp_rdy);
         if (v_i && exp_rdy) begin
            chk("mem_w_o", mem_w_o, w_i);
            chk("mem_addr_o", mem_addr_o, addr_i);
            chk("mem_data_o", mem_data_o, data_i);
         end
      end
   end

   task automatic drive(input logic v, input logic w, input int a,
                        input int d, input logic yen, output logic acc);
      v_i    = v;
      w_i    = w;
      addr_i = AW'(a);
      data_i = W'(d);
      yumi_i = yen && m_v && rst_n;
      #1;
      acc = mem_v_o;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic yen, input int n);
      logic a;
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, yen, a);
   endtask

   logic         a;
   int           nacc;
   int           idx;
   logic [W-1:0] got[$];
   int           gotk[$];

   initial begin
      @(posedge clk); #1;
      chk("rst_ready_1", ready_o, 0);
      chk("rst_v_o", v_o, 0);
      started = 1'b1;
      @(posedge clk); #1;
      chk("rst_ready_2", ready_o, 0);
      rst_n = 1'b1;

      for (int i = 0; i < ELS; i++) drive(1, 1, i, i ^ 8'h5A, 0, a);

      // write then read address 5, checking two-cycle latency
      drive(1, 1, 5, 8'hA5, 1, a);
      drive(1, 0, 5, 0, 1, a);
      chk("rd5_acc", a, 1);
      chk("lat_n1_v_o", v_o, 0);
      idle(1, 1);
      chk("lat_n2_v_o", v_o, 1);
      chk("rd5_data", data_o, 8'hA5);
      idle(1, 2);

      // streaming reads with continuous yumi
      for (int i = 0; i < 8; i++) drive(1, 1, i, i * 3, 1, a);
      nacc = 0;
      for (int k = 0; k < 12; k++) begin
         drive(k < 8, 0, k, 0, 1, a);
         if (k < 8 && a) nacc++;
         if (v_o) begin
            got.push_back(data_o);
            gotk.push_back(k);
         end
      end
      chk("stream_acc", nacc, 8);
      chk("stream_n", got.size(), 8);
      if (gotk.size() > 0) chk("stream_first", gotk[0], 1);
      for (int i = 0; i < got.size(); i++) begin
         chk("stream_data", got[i], i * 3);
         chk("stream_consec", gotk[i], gotk[0] + i);
      end

      // backpressure: three credits, then one more per yumi
      nacc = 0;
      idx  = 0;
      for (int k = 0; k < 6; k++) begin
         drive(1, 0, idx, 0, 0, a);
         if (a) begin
            nacc++;
            idx++;
         end
      end
      chk("bp_acc", nacc, 3);
      chk("bp_ready", ready_o, 0);
      chk("bp_head0", data_o, 0);
      drive(1, 0, idx, 0, 1, a);
      chk("bp_yumi_cycle_noacc", a, 0);
      drive(1, 0, idx, 0, 0, a);
      chk("bp_after_yumi_acc", a, 1);
      idle(0, 1);
      chk("bp_head1", data_o, 3);
      chk("bp_full_ready", ready_o, 0);

      // write blocked while full, accepted after a yumi, no response
      drive(1, 1, 10, 8'h5C, 0, a);
      chk("full_wr_blocked", a, 0);
      drive(1, 1, 10, 8'h5C, 1, a);
      chk("full_wr_yumi_cycle", a, 0);
      drive(1, 1, 10, 8'h5C, 0, a);
      chk("wr_after_yumi", a, 1);
      idle(0, 1);
      chk("wr_no_credit", ready_o, 1);
      chk("wr_head", data_o, 6);
      idle(1, 4);
      chk("drained_1", v_o, 0);

      // enqueue and dequeue in the same cycle with two queued
      drive(1, 0, 0, 0, 0, a);
      drive(1, 0, 1, 0, 0, a);
      drive(1, 0, 2, 0, 0, a);
      chk("same_head0", data_o, 0);
      idle(1, 1);
      chk("same_head1", data_o, 3);
      chk("same_ready", ready_o, 1);
      idle(1, 4);
      chk("drained_2", v_o, 0);

      // reset with one read in flight and two queued
      drive(1, 0, 0, 0, 0, a);
      drive(1, 0, 1, 0, 0, a);
      drive(1, 0, 2, 0, 0, a);
      rst_n = 1'b0;
      idle(0, 1);
      rst_n = 1'b1;
      chk("mid_rst_v_o", v_o, 0);
      for (int k = 0; k < 3; k++) begin
         idle(1, 1);
         chk("mid_rst_stale", v_o, 0);
      end
      drive(1, 0, 7, 0, 1, a);
      idle(1, 1);
      chk("post_rst_v_o", v_o, 1);
      chk("post_rst_data", data_o, 21);
      idle(1, 2);

      // random traffic against the reference
      for (int k = 0; k < 3000; k++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0,
               $urandom_range(0, ELS - 1), $urandom_range(0, 255),
               $urandom_range(0, 9) < 6, a);
      end
      rst_n = 1'b1;
      idle(1, 8);
      chk("final_empty", v_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
